// File: rtl/victim_writeback_buffer.sv
// Victim writeback buffer: absorbs dirty lines evicted from the victim cache, acks them
// immediately and drains them to memory in FIFO order. Read misses from the victim cache
// are forwarded from a buffered line on a tag match, or go to memory ahead of queued
// writebacks unless the buffer is full.
`timescale 1ns/1ps
module victim_writeback_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LINE_W = 128,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vc_write,
  input  logic              vc_read,
  input  logic [ADDR_W-1:0] vc_address,
  input  logic [LINE_W-1:0] vc_wdata,
  output logic [LINE_W-1:0] vc_rdata,
  output logic              vc_resp,
  output logic              vc_full,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned TagW = ADDR_W - 4;

  typedef enum logic [1:0] {StIdle, StDrain, StRead, StResp} state_e;

  state_e            state_q;
  logic [DEPTH-1:0]  valid_q;
  logic [TagW-1:0]   tag_q  [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];
  logic [PtrW-1:0]   head_q, tail_q;
  logic [CntW-1:0]   count_q, count_d;

  logic [TagW-1:0] req_tag;
  logic            hit;
  logic [PtrW-1:0] hit_idx;
  logic            full, pop;
  logic            wr_ok, wr_upd, wr_push;
  logic            rd_req_raw, rd_hit, rd_miss_ok, rd_miss_go, drain_go;
  logic            unused_addr_lsb;

  assign req_tag         = vc_address[ADDR_W-1:4];
  assign unused_addr_lsb = ^vc_address[3:0];

  // Associative tag lookup; valid tags are unique because a write to the draining head stalls.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (tag_q[i] == req_tag)) begin
        hit     = 1'b1;
        hit_idx = PtrW'(i);
      end
    end
  end

  // Request decode. The *_ok terms ignore vc_resp so a request still held through its
  // ack cycle (with new address/data) keeps the FSM from starting a drain underneath it.
  always_comb begin
    full = (count_q == CntW'(DEPTH));
    pop  = (state_q == StDrain) && mem_resp;
    wr_ok = vc_write
          && ((state_q == StIdle) || (state_q == StDrain) || ((state_q == StRead) && !mem_resp))
          && !(hit && (state_q == StDrain) && (hit_idx == head_q))
          && (hit || !full || pop);
    wr_upd  = wr_ok && !vc_resp && hit;
    wr_push = wr_ok && !vc_resp && !hit;
    rd_req_raw = vc_read && !vc_write && ((state_q == StIdle) || (state_q == StDrain));
    rd_hit     = rd_req_raw && !vc_resp && hit;
    rd_miss_ok = rd_req_raw && !hit && (state_q == StIdle) && !full;
    rd_miss_go = rd_miss_ok && !vc_resp;
    drain_go   = (state_q == StIdle) && (count_q != '0) && !rd_miss_ok && !wr_ok;
    count_d    = count_q + CntW'(wr_push) - CntW'(pop);
  end

  // FIFO storage, control FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      vc_rdata    <= '0;
      vc_resp     <= 1'b0;
      vc_full     <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
    end else begin
      vc_resp <= 1'b0;
      count_q <= count_d;
      vc_full <= (count_d == CntW'(DEPTH));

      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PtrW'(1);
      end
      if (wr_upd) begin
        data_q[hit_idx] <= vc_wdata;
        vc_resp         <= 1'b1;
      end
      // Placed after the pop so a push into the slot being freed (full case) wins.
      if (wr_push) begin
        valid_q[tail_q] <= 1'b1;
        tag_q[tail_q]   <= req_tag;
        data_q[tail_q]  <= vc_wdata;
        tail_q          <= tail_q + PtrW'(1);
        vc_resp         <= 1'b1;
      end
      if (rd_hit) begin
        vc_rdata <= data_q[hit_idx];
        vc_resp  <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (rd_miss_go) begin
            state_q     <= StRead;
            mem_read    <= 1'b1;
            mem_address <= {req_tag, 4'b0000};
          end else if (drain_go) begin
            state_q     <= StDrain;
            mem_write   <= 1'b1;
            mem_address <= {tag_q[head_q], 4'b0000};
            mem_wdata   <= data_q[head_q];
          end
        end
        StDrain: begin
          if (mem_resp) begin
            state_q   <= StIdle;
            mem_write <= 1'b0;
          end
        end
        StRead: begin
          if (mem_resp) begin
            state_q  <= StResp;
            mem_read <= 1'b0;
            vc_rdata <= mem_rdata;
            vc_resp  <= 1'b1;
          end
        end
        StResp: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
